// File: rtl/du_imem_loader_pkg.sv
// Shared debug-unit definitions for the instruction-memory load path.
// Holds the field widths, the wire-format byte counts and the FSM state encoding.
package du_imem_loader_pkg;

    localparam int NB_INSTR       = 32;
    localparam int NB_UART_DATA   = 8;
    localparam int NB_ADDR        = 32;
    localparam int NB_WCOUNT      = 16;
    localparam int IMEM_WORDS     = 256;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_RX_LEN  = 6'b000010,
        ST_RX_WORD = 6'b000100,
        ST_WRITE   = 6'b001000,
        ST_DONE    = 6'b010000,
        ST_ERROR   = 6'b100000
    } state_t;

endpackage

// File: rtl/du_imem_loader_if.sv
// Loader bus: command-decoder handshake, Rx FIFO read side and imem write port.
// The loader takes the master view; the surrounding debug unit takes the slave view.
interface du_imem_loader_if;
    import du_imem_loader_pkg::*;

    logic                    i_start;
    logic                    i_rx_empty;
    logic [NB_UART_DATA-1:0] i_rx_data;
    logic                    o_rd;
    logic                    o_imem_wr;
    logic [NB_ADDR-1:0]      o_imem_waddr;
    logic [NB_INSTR-1:0]     o_imem_wdata;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_error;

    modport master (
        input  i_start, i_rx_empty, i_rx_data,
        output o_rd, o_imem_wr, o_imem_waddr, o_imem_wdata, o_busy, o_done, o_error
    );

    modport slave (
        output i_start, i_rx_empty, i_rx_data,
        input  o_rd, o_imem_wr, o_imem_waddr, o_imem_wdata, o_busy, o_done, o_error
    );

endinterface

// File: rtl/du_imem_loader_byte_assembler.sv
// Little-endian byte assembler: each load drops a byte into the next lane.
// 'value' already includes the byte being loaded this cycle, so 'full' and 'value' can be used together.
module du_imem_loader_byte_assembler #(
    parameter int NBYTES  = 4,
    parameter int NB_BYTE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic [NB_BYTE-1:0]        data,
    output logic [NBYTES*NB_BYTE-1:0] value,
    output logic                      full
);
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [NBYTES*NB_BYTE-1:0] stored;
    logic [CNT_W-1:0]          cnt;

    always_comb begin
        value = stored;
        if (load)
            value[NB_BYTE*cnt +: NB_BYTE] = data;
    end

    assign full = load && (cnt == CNT_W'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stored <= '0;
            cnt    <= '0;
        end else if (clear) begin
            stored <= '0;
            cnt    <= '0;
        end else if (load) begin
            stored <= value;
            cnt    <= full ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/du_imem_loader.sv
// Debug-unit receive path: reads a LE word count then N LE instruction words from the
// Rx FIFO and writes them to consecutive imem word addresses, reporting done/error.
module du_imem_loader
    import du_imem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst,
    du_imem_loader_if.master bus
);
    state_t                  state;
    logic [NB_WCOUNT-1:0]    word_idx;
    logic [NB_WCOUNT-1:0]    len;
    logic [NB_INSTR-1:0]     word;
    logic                    len_full, word_full;
    logic                    rd, start_load;
    logic                    imem_wr, busy, done, error;
    logic [NB_ADDR-1:0]      waddr;
    logic [NB_INSTR-1:0]     wdata;

    // Pop is combinational so the head byte is consumed in the same cycle it is seen.
    assign rd         = (state == ST_RX_LEN || state == ST_RX_WORD) && !bus.i_rx_empty;
    assign start_load = (state == ST_IDLE) && bus.i_start;

    du_imem_loader_byte_assembler #(.NBYTES(LEN_BYTES), .NB_BYTE(NB_UART_DATA)) len_asm (
        .clk   (clk),
        .rst   (i_rst),
        .clear (start_load),
        .load  (rd && state == ST_RX_LEN),
        .data  (bus.i_rx_data),
        .value (len),
        .full  (len_full)
    );

    du_imem_loader_byte_assembler #(.NBYTES(BYTES_PER_WORD), .NB_BYTE(NB_UART_DATA)) word_asm (
        .clk   (clk),
        .rst   (i_rst),
        .clear (start_load),
        .load  (rd && state == ST_RX_WORD),
        .data  (bus.i_rx_data),
        .value (word),
        .full  (word_full)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            imem_wr  <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            imem_wr <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            case (state)
                ST_IDLE: if (bus.i_start) begin
                    state    <= ST_RX_LEN;
                    word_idx <= '0;
                    busy     <= 1'b1;
                end
                ST_RX_LEN: if (len_full) begin
                    if (len == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (len > NB_WCOUNT'(IMEM_WORDS)) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end else begin
                        state <= ST_RX_WORD;
                    end
                end
                // Output registers are loaded on entry so the write pulse lines up with WRITE.
                ST_RX_WORD: if (word_full) begin
                    state   <= ST_WRITE;
                    imem_wr <= 1'b1;
                    waddr   <= NB_ADDR'({word_idx, 2'b00});
                    wdata   <= word;
                end
                ST_WRITE: begin
                    if (word_idx + NB_WCOUNT'(1) == len) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        word_idx <= word_idx + NB_WCOUNT'(1);
                        state    <= ST_RX_WORD;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rd         = rd;
    assign bus.o_imem_wr    = imem_wr;
    assign bus.o_imem_waddr = waddr;
    assign bus.o_imem_wdata = wdata;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;
    assign bus.o_error      = error;

endmodule

// File: tb/tb_du_imem_loader.sv
// Bench for du_imem_loader: a queue-backed Rx FIFO feeds byte streams, a monitor logs
// pops/writes/pulses per cycle, and each load is scored against the wire-format rules.
module tb_du_imem_loader;
    import du_imem_loader_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    du_imem_loader_if bus();

    du_imem_loader dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model and event log
    logic [7:0]  q[$];
    int          gap_cnt = 0, gap_max = 0;
    bit          gap_fixed = 1'b0;
    bit          pop_pend = 1'b0;
    int          cyc = 0;
    int          pop_cyc[$];
    logic [31:0] wr_addr[$], wr_data[$];
    int          wr_cyc[$];
    int          n_done = 0, n_err = 0, end_cyc = -1;
    int          n_rd_empty = 0, n_idle_bus = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        if (pop_pend && q.size() > 0) begin
            q.delete(0);
            gap_cnt = gap_fixed ? gap_max : $urandom_range(0, gap_max);
        end
        if (gap_cnt > 0) begin
            bus.i_rx_empty = 1'b1;
            gap_cnt--;
        end else begin
            bus.i_rx_empty = (q.size() == 0);
        end
        bus.i_rx_data = (q.size() > 0) ? q[0] : 8'h00;
        #1;
        pop_pend = bus.o_rd && !bus.i_rx_empty;
        if (bus.o_rd) begin
            if (bus.i_rx_empty) n_rd_empty++;
            pop_cyc.push_back(cyc);
        end
        if (bus.o_imem_wr) begin
            wr_addr.push_back(bus.o_imem_waddr);
            wr_data.push_back(bus.o_imem_wdata);
            wr_cyc.push_back(cyc);
        end else if (bus.o_imem_waddr != '0 || bus.o_imem_wdata != '0) begin
            n_idle_bus++;
        end
        if (bus.o_done)  begin n_done++; end_cyc = cyc; end
        if (bus.o_error) begin n_err++;  end_cyc = cyc; end
    end

    task automatic clear_rec();
        pop_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        n_done = 0; n_err = 0; end_cyc = -1; n_rd_empty = 0; n_idle_bus = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {bus.o_rd, bus.o_imem_wr, bus.o_busy, bus.o_done, bus.o_error}, '0);
        chk({tag, "_addr"}, bus.o_imem_waddr, '0);
        chk({tag, "_data"}, bus.o_imem_wdata, '0);
    endtask

    function automatic bq_t mk(input int n, input int payload_words);
        bq_t s;
        logic [15:0] nn;
        nn = 16'(n);
        s.push_back(nn[7:0]);
        s.push_back(nn[15:8]);
        for (int i = 0; i < payload_words * 4; i++) s.push_back(8'($urandom_range(0, 255)));
        return s;
    endfunction

    task automatic start_pulse();
        @(negedge clk); #2;
        bus.i_start = 1'b1;
        @(negedge clk); #2;
        bus.i_start = 1'b0;
    endtask

    // One full load; expectations come from the wire format, not from the RTL.
    task automatic do_load(input bq_t s, input int gmax, input bit gfix, input bit spam);
        int n, ok_n, exp_pops, ref_c;
        logic [31:0] ed;
        clear_rec();
        gap_max = gmax; gap_fixed = gfix; gap_cnt = 0;
        q = s;
        start_pulse();
        chk("busy_on", bus.o_busy, 1'b1);
        begin
            bit ended = 1'b0;
            for (int k = 0; k < 20000; k++) begin
                @(negedge clk); #2;
                if (n_done + n_err > 0) begin ended = 1'b1; break; end
                bus.i_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.i_start = 1'b0;
            if (!ended) chk("timeout", 1'b1, 1'b0);
        end
        @(negedge clk); #2;
        chk("busy_idle", bus.o_busy, 1'b0);

        n = int'({s[1], s[0]});
        ok_n = (n <= IMEM_WORDS) ? n : 0;
        exp_pops = (n <= IMEM_WORDS) ? 2 + 4 * n : 2;
        chk("done_cnt", n_done, (n <= IMEM_WORDS) ? 1 : 0);
        chk("err_cnt", n_err, (n > IMEM_WORDS) ? 1 : 0);
        chk("pops", pop_cyc.size(), exp_pops);
        chk("n_writes", wr_addr.size(), ok_n);
        for (int i = 0; i < ok_n && i < wr_addr.size(); i++) begin
            ed = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
            chk("wr_addr", wr_addr[i], 32'(4 * i));
            chk("wr_data", wr_data[i], ed);
            if (pop_cyc.size() > 2 + 4 * i + 3)
                chk("wr_lat", wr_cyc[i], pop_cyc[2+4*i+3] + 1);
        end
        if (ok_n > 0 && wr_cyc.size() > 0) ref_c = wr_cyc[wr_cyc.size()-1];
        else if (pop_cyc.size() >= 2)      ref_c = pop_cyc[1];
        else                               ref_c = -10;
        chk("end_lat", end_cyc, ref_c + 1);
        chk("rd_while_empty", n_rd_empty, 0);
        chk("bus_outside_wr", n_idle_bus, 0);
        q.delete();
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t t2, t3, t4, s;
        t2 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        t3 = '{8'h00, 8'h00};
        t4 = '{8'h2C, 8'h01};
        rst = 1'b1;
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk_quiet("reset");
        rst = 1'b0;

        do_load(t2, 0, 1'b0, 1'b0);
        if (wr_data.size() >= 2) begin
            chk("t2_word0", wr_data[0], 32'h00500093);
            chk("t2_word1", wr_data[1], 32'h00000013);
        end
        do_load(t3, 0, 1'b0, 1'b0);
        do_load(t4, 0, 1'b0, 1'b0);
        do_load(t2, 10, 1'b1, 1'b1);

        // Reset mid-word, then replay the same stream from scratch.
        clear_rec();
        gap_max = 0; gap_fixed = 1'b0; gap_cnt = 0;
        q = t2;
        start_pulse();
        for (int k = 0; k < 200 && pop_cyc.size() < 6; k++) begin
            @(negedge clk); #2;
        end
        chk("pre_rst_pops", pop_cyc.size(), 6);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_quiet("mid_rst");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        q.delete();
        repeat (4) @(negedge clk);
        #2;
        chk("no_spur_wr", wr_addr.size(), 0);
        chk("no_spur_done", n_done + n_err, 0);
        do_load(t2, 0, 1'b0, 1'b0);

        // Capacity boundaries
        do_load(mk(IMEM_WORDS, IMEM_WORDS), 0, 1'b0, 1'b0);
        if (wr_addr.size() == IMEM_WORDS)
            chk("last_addr", wr_addr[IMEM_WORDS-1], 32'((IMEM_WORDS - 1) * 4));
        do_load(mk(IMEM_WORDS + 1, 2), 1, 1'b0, 1'b0);

        for (int r = 0; r < 14; r++) begin
            int kind, n, pw;
            kind = $urandom_range(0, 5);
            if (kind == 0)      begin n = 0; pw = 0; end
            else if (kind == 1) begin n = $urandom_range(IMEM_WORDS + 1, 65535); pw = $urandom_range(0, 2); end
            else                begin n = $urandom_range(1, 6); pw = n; end
            s = mk(n, pw);
            do_load(s, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
